// File: rtl/ex_result_stage.sv
//==============================================================================
// Module   : ex_result_stage
// Purpose  : Execute-stage result buffer. A 2-entry in-order FIFO holds ALU
//            beats {result, flags, set_flags, rd, reg_write}. Flags are written
//            into the architectural NZVC register when their entry pops.
//            A combinational condition-code evaluator reads a selected NZVC
//            source and drives cond_true.
//
// Ports    : clk           - rising-edge clock
//            reset         - synchronous, active-high clear
//            in_valid      - ALU beat present
//            in_ready      - a beat can be accepted (occupancy < 2)
//            alu_result    - 64-bit ALU result
//            alu_flags     - {N, Z, V, C} from the ALU
//            set_flags     - beat's flags commit to the flags register on pop
//            rd, reg_write - destination index / write enable
//            flush         - discard every buffered beat
//            out_valid     - head entry valid
//            out_ready     - consumer accepts the head entry
//            out_result, out_rd, out_reg_write - head entry fields
//            flags         - committed architectural NZVC
//            cond          - condition code to evaluate
//            cond_true     - evaluation result (combinational)
//
// Config   : EX_FLAG_BYPASS_EN - when defined, cond_true reads the flags of
//            the youngest buffered entry with set_flags=1, falling back to the
//            committed register. When undefined, only the committed register
//            is used.
//
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_result_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] alu_result,
    input  logic [3:0]  alu_flags,
    input  logic        set_flags,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [3:0]  flags,
    input  logic [3:0]  cond,
    output logic        cond_true
);

    localparam logic [1:0] c_FULL  = 2'd2;
    localparam logic [1:0] c_EMPTY = 2'd0;

    // Condition codes
    localparam logic [3:0] c_EQ = 4'd0;
    localparam logic [3:0] c_NE = 4'd1;
    localparam logic [3:0] c_HS = 4'd2;
    localparam logic [3:0] c_LO = 4'd3;
    localparam logic [3:0] c_MI = 4'd4;
    localparam logic [3:0] c_PL = 4'd5;
    localparam logic [3:0] c_VS = 4'd6;
    localparam logic [3:0] c_VC = 4'd7;
    localparam logic [3:0] c_HI = 4'd8;
    localparam logic [3:0] c_LS = 4'd9;
    localparam logic [3:0] c_GE = 4'd10;
    localparam logic [3:0] c_LT = 4'd11;
    localparam logic [3:0] c_GT = 4'd12;
    localparam logic [3:0] c_LE = 4'd13;

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [1:0][63:0] r_result;
    logic [1:0][3:0]  r_eflags;
    logic [1:0]       r_setf;
    logic [1:0][4:0]  r_rd;
    logic [1:0]       r_rw;

    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [3:0]       r_flags;

    logic             w_push;
    logic             w_pop;
    logic             w_tail_ptr;
    logic [3:0]       w_src;
    logic             w_n;
    logic             w_z;
    logic             w_v;
    logic             w_c;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != c_EMPTY);

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // When two entries are held, the younger one sits opposite the head.
    assign w_tail_ptr = ~r_rd_ptr;

    assign out_result    = r_result[r_rd_ptr];
    assign out_rd        = r_rd[r_rd_ptr];
    assign out_reg_write = r_rw[r_rd_ptr];
    assign flags         = r_flags;

    // ------------------------------------------------------------------
    // Entry payload. No reset: contents of empty slots are don't-care and
    // a write during a flush or reset cycle is never observed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_result[r_wr_ptr] <= alu_result;
            r_eflags[r_wr_ptr] <= alu_flags;
            r_setf[r_wr_ptr]   <= set_flags;
            r_rd[r_wr_ptr]     <= rd;
            r_rw[r_wr_ptr]     <= reg_write;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy, pointers and committed flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= c_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_flags  <= 4'b0000;
        end else begin
            // A pop that coincides with a flush still retires its entry,
            // so its flags commit regardless of flush.
            if (w_pop && r_setf[r_rd_ptr]) begin
                r_flags <= r_eflags[r_rd_ptr];
            end

            if (flush) begin
                r_count  <= c_EMPTY;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Flag source for condition evaluation
    // ------------------------------------------------------------------
`ifdef EX_FLAG_BYPASS_EN
    // Youngest buffered flag-setting entry wins; the tail check comes last
    // so it overrides the head when both set flags.
    always_comb begin
        w_src = r_flags;
        if ((r_count != c_EMPTY) && r_setf[r_rd_ptr]) begin
            w_src = r_eflags[r_rd_ptr];
        end
        if ((r_count == c_FULL) && r_setf[w_tail_ptr]) begin
            w_src = r_eflags[w_tail_ptr];
        end
    end
`else
    assign w_src = r_flags;
`endif

    assign w_n = w_src[3];
    assign w_z = w_src[2];
    assign w_v = w_src[1];
    assign w_c = w_src[0];

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            c_EQ:    cond_true = w_z;
            c_NE:    cond_true = !w_z;
            c_HS:    cond_true = w_c;
            c_LO:    cond_true = !w_c;
            c_MI:    cond_true = w_n;
            c_PL:    cond_true = !w_n;
            c_VS:    cond_true = w_v;
            c_VC:    cond_true = !w_v;
            c_HI:    cond_true = w_c && !w_z;
            c_LS:    cond_true = !(w_c && !w_z);
            c_GE:    cond_true = (w_n == w_v);
            c_LT:    cond_true = (w_n != w_v);
            c_GT:    cond_true = !w_z && (w_n == w_v);
            c_LE:    cond_true = !(!w_z && (w_n == w_v));
            default: cond_true = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 The block SHALL have one clock, `clk`; reset `reset` SHALL be synchronous and active-high.
REQ-002 Port `clk`: input, 1 bit; rising-edge clock for all state.
REQ-003 Port `reset`: input, 1 bit; synchronous, active-high clear.
REQ-004 Port `in_valid`: input, 1 bit; ALU output beat is present.
REQ-005 Port `in_ready`: output, 1 bit; the block can accept a beat.
REQ-006 Port `alu_result`: input, 64 bits; ALU result.
REQ-007 Port `alu_flags`: input, 4 bits; {negative, zero, overflow, carry_out} from the ALU.
REQ-008 Port `set_flags`: input, 1 bit; the beat's flags commit to the flags register.
REQ-009 Port `rd`: input, 5 bits; destination register index.
REQ-010 Port `reg_write`: input, 1 bit; destination write enable.
REQ-011 Port `flush`: input, 1 bit; discard all buffered beats.
REQ-012 Port `out_valid`: output, 1 bit; head entry is valid.
REQ-013 Port `out_ready`: input, 1 bit; consumer accepts the head entry.
REQ-014 Ports `out_result`, `out_rd`, `out_reg_write`: outputs, 64, 5 and 1 bits; head entry fields.
REQ-015 Port `flags`: output, 4 bits; committed architectural NZVC.
REQ-016 Port `cond`: input, 4 bits; condition code to evaluate.
REQ-017 Port `cond_true`: output, 1 bit; combinational result of evaluating `cond`.

Function
REQ-018 The block SHALL buffer beats in a 2-entry in-order FIFO holding {result, flags, set_flags, rd, reg_write}.
- Push: `in_valid && in_ready`.
- Pop: `out_valid && out_ready`.
REQ-019 `in_ready` SHALL be 1 when the occupancy is below 2, regardless of `out_ready`; it has no combinational path from `out_ready`.
REQ-020 Latency from push to `out_valid` SHALL be 1 cycle when the FIFO is empty.
REQ-021 Simultaneous push and pop at occupancy 1 SHALL keep the occupancy at 1 and present the new beat next cycle.
REQ-022 Outputs SHALL hold stable while `out_valid && !out_ready`.
REQ-023 On pop of an entry with `set_flags=1`, `flags` SHALL take that entry's flags on the next edge; entries with `set_flags=0` SHALL leave `flags` unchanged.
REQ-024 `flush` SHALL set the occupancy to 0 on the next edge.
- `flush` has priority over a same-cycle push and pop.
- A pop coincident with `flush` still commits its flags.
- Flushed entries never commit.
REQ-025 `cond_true` SHALL be evaluated using NZVC from the selected flag source (REQ-030/031):
- 0 EQ: Z; 1 NE: !Z
- 2 HS: C; 3 LO: !C
- 4 MI: N; 5 PL: !N
- 6 VS: V; 7 VC: !V
- 8 HI: C&!Z; 9 LS: !(C&!Z)
- 10 GE: N==V; 11 LT: N!=V
- 12 GT: !Z&(N==V); 13 LE: !(!Z&(N==V))
- 14 and 15: 1
REQ-026 Data fields of empty entries are don't-care; `out_result` and the other head fields SHALL be ignored while `out_valid=0`.

Reset
REQ-027 When `reset` is high at the rising edge:
- the occupancy SHALL become 0;
- `out_valid` SHALL be 0;
- `flags` SHALL be 4'b0000;
- the FIFO pointers SHALL be 0.
REQ-028 `reset` SHALL override push, pop and `flush` in the same cycle; a beat in flight during reset is lost.
REQ-029 `in_ready` SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-030 With macro `EX_FLAG_BYPASS_EN` defined, `cond_true` SHALL use the flags of the youngest buffered entry having `set_flags=1`; if no such entry exists, it SHALL use `flags`.
REQ-031 Without `EX_FLAG_BYPASS_EN`, `cond_true` SHALL use only the committed `flags` register.

Verification
REQ-032 Reset then push {result=64'h5, flags=4'b0000, set_flags=0, rd=3, reg_write=1} with `out_ready=1` -> next cycle `out_valid=1`, `out_result=5`, `out_rd=3`; the cycle after, `out_valid=0`; `flags` stays 0.
REQ-033 Hold `out_ready=0` and push 3 beats -> `in_ready=0` after the 2nd push; the 3rd beat is not accepted; the head shows the 1st beat unchanged.
REQ-034 Push {flags=4'b0100, set_flags=1} with `cond=0` (EQ) -> `flags=4'b0100` the cycle after the pop and `cond_true=1`; with `cond=1` (NE), `cond_true=0`.
REQ-035 Occupancy 2, then `flush` and `in_valid` together -> next cycle occupancy 0, `out_valid=0`, `flags` unchanged.
REQ-036 `EX_FLAG_BYPASS_EN` defined: buffer {flags=4'b1000, set_flags=1} with `out_ready=0` and `cond=4` (MI) -> `cond_true=1` while the entry is buffered; without the macro, `cond_true=0` until the pop commits.
